// File: rtl/counter_pkg.sv
// Shared definitions for the multi-mode counter and its command sequencer.
package counter_pkg;

  localparam logic [1:0] COUNT_UP     = 2'b00;
  localparam logic [1:0] COUNT_DOWN   = 2'b01;
  localparam logic [1:0] COUNT_3_DOWN = 2'b10;
  localparam logic [1:0] CHARGE       = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPreload,
    StRun,
    StDrain,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/counter_seq_rco_capture.sv
// Falling-edge capture of the half-cycle RCO pulse plus a saturating WRAPS counter.
module counter_seq_rco_capture #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              rco,
  input  logic              clear,
  input  logic              count_en,
  output logic [WRAP_W-1:0] wraps
);

  logic              rco_cap_q;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  // RCO is gone by the next rising edge, so catch it on the falling edge in between.
  always_ff @(negedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rco_cap_q <= 1'b0;
    end else begin
      rco_cap_q <= rco;
    end
  end

  always_comb begin
    wraps_d = wraps_q;
    if (clear) begin
      wraps_d = '0;
    end else if (count_en && rco_cap_q && (wraps_q != '1)) begin
      wraps_d = wraps_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wraps_q <= '0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

  assign wraps = wraps_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven front end for the 4-bit multi-mode counter.
// Optional abort support (CMD_ABORT, CNT_LOAD check) is built when COUNTER_SEQ_ABORT_EN is defined.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_MODO,
  input  logic              CMD_PRELOAD,
  input  logic [CNT_W-1:0]  CMD_D,
  input  logic [LEN_W-1:0]  CMD_LEN,
`ifdef COUNTER_SEQ_ABORT_EN
  input  logic              CMD_ABORT,
`endif
  input  logic              CNT_RCO,
  input  logic              CNT_LOAD,
  output logic              CNT_ENABLE,
  output logic [1:0]        CNT_MODO,
  output logic [CNT_W-1:0]  CNT_D,
  output logic              BUSY,
  output logic              DONE,
  output logic [WRAP_W-1:0] WRAPS
);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       modo_q;
  logic [CNT_W-1:0] d_q;
  logic             accept;
  logic             abort;

  assign accept = (state_q == StIdle) && CMD_VALID;

`ifdef COUNTER_SEQ_ABORT_EN
  // Flags the first RUN cycle after a CHARGE edge, where CNT_LOAD must confirm the preload.
  logic load_chk_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      load_chk_q <= 1'b0;
    end else begin
      load_chk_q <= (state_q == StPreload);
    end
  end

  assign abort = ((state_q == StPreload) && CMD_ABORT) ||
                 ((state_q == StRun) && (CMD_ABORT || (load_chk_q && !CNT_LOAD)));
`else
  logic unused_cnt_load;
  assign unused_cnt_load = CNT_LOAD;
  assign abort           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          len_d = CMD_LEN;
          // Zero-length commands still pass through DRAIN so DONE latency is uniform.
          if (CMD_LEN == '0) begin
            state_d = StDrain;
          end else if (CMD_PRELOAD) begin
            state_d = StPreload;
          end else begin
            state_d = StRun;
          end
        end
      end
      StPreload: state_d = abort ? StDrain : StRun;
      StRun: begin
        len_d = len_q - LEN_W'(1);
        if (abort || (len_q == LEN_W'(1))) begin
          state_d = StDrain;
          len_d   = '0;
        end
      end
      StDrain:  state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      len_q   <= '0;
      modo_q  <= COUNT_UP;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      if (accept) begin
        modo_q <= CMD_MODO;
        d_q    <= CMD_D;
      end
    end
  end

  always_comb begin
    CMD_READY  = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    CNT_ENABLE = 1'b0;
    CNT_MODO   = COUNT_UP;
    CNT_D      = '0;
    unique case (state_q)
      StIdle: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
      end
      StPreload: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = CHARGE;
        CNT_D      = d_q;
      end
      StRun: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = modo_q;
        CNT_D      = d_q;
      end
      StFinish: DONE = 1'b1;
      default: ;
    endcase
  end

  counter_seq_rco_capture #(
    .WRAP_W (WRAP_W)
  ) u_rco_capture (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .rco      (CNT_RCO),
    .clear    (accept),
    .count_en ((state_q == StRun) || (state_q == StDrain)),
    .wraps    (WRAPS)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit counter model downstream.
module tb_counter_sequencer;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       CMD_VALID, CMD_READY, CMD_PRELOAD;
  logic [1:0] CMD_MODO;
  logic [3:0] CMD_D;
  logic [7:0] CMD_LEN;
  logic       CNT_RCO, CNT_LOAD, CNT_ENABLE, BUSY, DONE;
  logic [1:0] CNT_MODO;
  logic [3:0] CNT_D;
  logic [1:0] WRAPS;
`ifdef COUNTER_SEQ_ABORT_EN
  logic       CMD_ABORT = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_sequencer #(
    .CNT_W  (4),
    .LEN_W  (8),
    .WRAP_W (2)
  ) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_MODO    (CMD_MODO),
    .CMD_PRELOAD (CMD_PRELOAD),
    .CMD_D       (CMD_D),
    .CMD_LEN     (CMD_LEN),
`ifdef COUNTER_SEQ_ABORT_EN
    .CMD_ABORT   (CMD_ABORT),
`endif
    .CNT_RCO     (CNT_RCO),
    .CNT_LOAD    (CNT_LOAD),
    .CNT_ENABLE  (CNT_ENABLE),
    .CNT_MODO    (CNT_MODO),
    .CNT_D       (CNT_D),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .WRAPS       (WRAPS)
  );

  // Counter model: ENABLE=0 clears Q; RCO on reaching F (up) or 0 (down modes), never on CHARGE.
  logic [3:0] model_q = 4'h0;
  logic [3:0] model_nq;
  logic [3:0] q_log[$];

  initial CNT_RCO = 1'b0;

  always @(posedge clk) begin
    model_nq = 4'h0;
    if (CNT_ENABLE) begin
      case (CNT_MODO)
        COUNT_UP:     model_nq = model_q + 4'd1;
        COUNT_DOWN:   model_nq = model_q - 4'd1;
        COUNT_3_DOWN: model_nq = model_q - 4'd3;
        default:      model_nq = CNT_D;
      endcase
      q_log.push_back(model_nq);
      CNT_RCO <= ((CNT_MODO == COUNT_UP) && (model_nq == 4'hF)) ||
                 (((CNT_MODO == COUNT_DOWN) || (CNT_MODO == COUNT_3_DOWN)) && (model_nq == 4'h0));
    end
    model_q <= model_nq;
  end

  always @(negedge clk) CNT_RCO <= 1'b0;

  // Issue one command and wait (bounded) for DONE; done_edge counts edges after the accept edge.
  task automatic run_cmd(input logic pre, input logic [3:0] d, input logic [1:0] modo,
                         input logic [7:0] len, output int done_edge, output int en_cycles,
                         output logic [1:0] wraps_first);
    done_edge   = -1;
    en_cycles   = 0;
    wraps_first = 2'bxx;
    @(negedge clk);
    CMD_PRELOAD = pre;
    CMD_D       = d;
    CMD_MODO    = modo;
    CMD_LEN     = len;
    CMD_VALID   = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    q_log.delete();
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) wraps_first = WRAPS;
      if (CNT_ENABLE) en_cycles++;
      if (DONE) begin
        done_edge = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N     = 1'b0;
    CMD_VALID   = 1'b0;
    CMD_PRELOAD = 1'b0;
    CMD_MODO    = 2'b00;
    CMD_D       = 4'h0;
    CMD_LEN     = 8'd0;
    CNT_LOAD    = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (CNT_ENABLE !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", CNT_ENABLE); end
    checks++; if (CNT_MODO !== 2'b00) begin failures++; $display("FAIL reset_modo got=%b exp=00", CNT_MODO); end
    checks++; if (CNT_D !== 4'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", CNT_D); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
    checks++; if (WRAPS !== 2'd0) begin failures++; $display("FAIL reset_wraps got=%0d exp=0", WRAPS); end
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_preload_up();
    int de, en;
    logic [1:0] w0;
    logic [15:0] seq;
    run_cmd(1'b1, 4'hE, COUNT_UP, 8'd3, de, en, w0);
    seq = (q_log.size() == 4) ? {q_log[0], q_log[1], q_log[2], q_log[3]} : 16'hxxxx;
    checks++; if (de !== 5) begin failures++; $display("FAIL up_done_latency got=%0d exp=5", de); end
    checks++; if (en !== 4) begin failures++; $display("FAIL up_enable_cycles got=%0d exp=4", en); end
    checks++; if (seq !== 16'hEF01) begin failures++; $display("FAIL up_q_seq got=%h exp=EF01", seq); end
    checks++; if (WRAPS !== 2'd1) begin failures++; $display("FAIL up_wraps got=%0d exp=1", WRAPS); end
    @(negedge clk);
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL up_done_width got=%b exp=0", DONE); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL up_idle_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_preload_down3();
    int de, en;
    logic [1:0] w0;
    logic [19:0] seq;
    run_cmd(1'b1, 4'h9, COUNT_3_DOWN, 8'd4, de, en, w0);
    seq = (q_log.size() == 5) ? {q_log[0], q_log[1], q_log[2], q_log[3], q_log[4]} : 20'hxxxxx;
    checks++; if (w0 !== 2'd0) begin failures++; $display("FAIL d3_wraps_clear got=%0d exp=0", w0); end
    checks++; if (de !== 6) begin failures++; $display("FAIL d3_done_latency got=%0d exp=6", de); end
    checks++; if (en !== 5) begin failures++; $display("FAIL d3_enable_cycles got=%0d exp=5", en); end
    checks++; if (seq !== 20'h9630D) begin failures++; $display("FAIL d3_q_seq got=%h exp=9630D", seq); end
    checks++; if (WRAPS !== 2'd1) begin failures++; $display("FAIL d3_wraps got=%0d exp=1", WRAPS); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int de, en;
    logic [1:0] w0;
    run_cmd(1'b0, 4'h0, COUNT_UP, 8'd80, de, en, w0);
    checks++; if (w0 !== 2'd0) begin failures++; $display("FAIL sat_wraps_clear got=%0d exp=0", w0); end
    checks++; if (de !== 81) begin failures++; $display("FAIL sat_done_latency got=%0d exp=81", de); end
    checks++; if (en !== 80) begin failures++; $display("FAIL sat_enable_cycles got=%0d exp=80", en); end
    checks++; if (WRAPS !== 2'd3) begin failures++; $display("FAIL sat_wraps got=%0d exp=3", WRAPS); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [8:0] mask = '0;
    logic       en_seen = 1'b0;
    CMD_PRELOAD = 1'b0;
    CMD_LEN     = 8'd0;
    CMD_VALID   = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      mask[n-1] = DONE;
      if (CNT_ENABLE) en_seen = 1'b1;
    end
    CMD_VALID = 1'b0;
    checks++; if (mask !== 9'b010010010) begin failures++; $display("FAIL len0_done_pattern got=%b exp=010010010", mask); end
    checks++; if (en_seen !== 1'b0) begin failures++; $display("FAIL len0_enable got=%b exp=0", en_seen); end
    checks++; if (WRAPS !== 2'd0) begin failures++; $display("FAIL len0_wraps got=%0d exp=0", WRAPS); end
    @(negedge clk);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL len0_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    @(negedge clk);
    CMD_PRELOAD = 1'b1;
    CMD_D       = 4'hE;
    CMD_MODO    = COUNT_UP;
    CMD_LEN     = 8'd10;
    CMD_VALID   = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (WRAPS !== 2'd1) begin failures++; $display("FAIL mrst_wraps_before got=%0d exp=1", WRAPS); end
    checks++; if (CNT_ENABLE !== 1'b1) begin failures++; $display("FAIL mrst_enable_before got=%b exp=1", CNT_ENABLE); end
    RESET_N = 1'b0;
    #1;
    checks++; if (CNT_ENABLE !== 1'b0) begin failures++; $display("FAIL mrst_enable got=%b exp=0", CNT_ENABLE); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", BUSY); end
    checks++; if (WRAPS !== 2'd0) begin failures++; $display("FAIL mrst_wraps got=%0d exp=0", WRAPS); end
    @(negedge clk);
    RESET_N = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL mrst_no_done got=%0d exp=0", dones); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL mrst_idle got=%b exp=0", BUSY); end
  endtask

`ifdef COUNTER_SEQ_ABORT_EN
  task automatic test_abort();
    int de = -1;
    int en = 0;
    @(negedge clk);
    CMD_PRELOAD = 1'b1;
    CMD_D       = 4'hD;
    CMD_MODO    = COUNT_UP;
    CMD_LEN     = 8'd10;
    CMD_VALID   = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      CMD_ABORT = (n == 4);
      if (CNT_ENABLE) en++;
      if (DONE) begin
        de = n - 1;
        break;
      end
    end
    CMD_ABORT = 1'b0;
    checks++; if (de !== 5) begin failures++; $display("FAIL abort_done_latency got=%0d exp=5", de); end
    checks++; if (en !== 4) begin failures++; $display("FAIL abort_enable_cycles got=%0d exp=4", en); end
    checks++; if (WRAPS !== 2'd1) begin failures++; $display("FAIL abort_wraps got=%0d exp=1", WRAPS); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_preload_up();
    test_preload_down3();
    test_saturate();
    test_back_to_back();
    test_mid_reset();
`ifdef COUNTER_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
